// File: rtl/m_axi_reg_slice_cfg_if.sv
// Valid/ready stream bundle used on both sides of m_axi_reg_slice_cfg.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface m_axi_reg_slice_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/m_axi_reg_slice_cfg.sv
// Configurable valid/ready register slice: bypass, forward, backward (skid) or full 2-entry.
// Optional synchronous flush input is enabled by defining REG_SLICE_FLUSH_EN.
module m_axi_reg_slice_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  m_axi_reg_slice_cfg_if.slave  s,
  m_axi_reg_slice_cfg_if.master m,
`ifdef REG_SLICE_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [1:0]            occupancy
);

  localparam int MODE_BYPASS = 32'sd0;
  localparam int MODE_FWD    = 32'sd1;
  localparam int MODE_BWD    = 32'sd2;
  localparam int MODE_FULL   = 32'sd3;

  logic flush_s;
`ifdef REG_SLICE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  generate
    if ((DATA_WIDTH < 32'sd1) || (MODE < MODE_BYPASS) || (MODE > MODE_FULL)) begin : g_bad_cfg
      $error("m_axi_reg_slice_cfg: MODE must be 0..3 and DATA_WIDTH >= 1");
    end else if (MODE == MODE_BYPASS) begin : g_bypass
      assign m.data    = s.data;
      assign m.valid   = s.valid;
      assign s.ready   = m.ready;
      assign occupancy = 2'd0;
    end else if (MODE == MODE_FWD) begin : g_fwd
      logic                  valid_r;
      logic [DATA_WIDTH-1:0] data_r;
      logic                  s_ready_s;

      // The output stage may refill in the same cycle it drains.
      assign s_ready_s = ~valid_r | m.ready;
      assign s.ready   = s_ready_s;
      assign m.valid   = valid_r;
      assign m.data    = data_r;
      assign occupancy = {1'b0, valid_r};

      // Output valid bit: cleared by reset/flush, reloaded whenever the stage can accept.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_r <= 1'b0;
        end else if (flush_s) begin
          valid_r <= 1'b0;
        end else if (s_ready_s) begin
          valid_r <= s.valid;
        end else begin
          valid_r <= valid_r;
        end
      end

      // Payload register, captured only on an upstream transfer.
      always_ff @(posedge clk) begin
        if (s.valid && s_ready_s) begin
          data_r <= s.data;
        end else begin
          data_r <= data_r;
        end
      end
    end else if (MODE == MODE_BWD) begin : g_bwd
      logic                  skid_r;
      logic [DATA_WIDTH-1:0] skid_data_r;

      assign s.ready   = ~skid_r;
      assign m.valid   = s.valid | skid_r;
      assign m.data    = skid_r ? skid_data_r : s.data;
      assign occupancy = {1'b0, skid_r};

      // Skid flag: fills when an accepted word cannot pass straight through, drains on m.ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          skid_r <= 1'b0;
        end else if (flush_s) begin
          skid_r <= 1'b0;
        end else if (skid_r) begin
          skid_r <= ~m.ready;
        end else begin
          skid_r <= s.valid & ~m.ready;
        end
      end

      // Skid payload, captured on the same condition that sets the skid flag.
      always_ff @(posedge clk) begin
        if (!skid_r && s.valid && !m.ready) begin
          skid_data_r <= s.data;
        end else begin
          skid_data_r <= skid_data_r;
        end
      end
    end else begin : g_full
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
      } state_t;

      state_t                state_r;
      logic                  s_ready_r;
      logic                  m_valid_r;
      logic [1:0]            occ_r;
      logic [DATA_WIDTH-1:0] p1_r;
      logic [DATA_WIDTH-1:0] p2_r;
      logic                  s_xfer_s;

      assign s_xfer_s  = s.valid & s_ready_r;
      assign s.ready   = s_ready_r;
      assign m.valid   = m_valid_r;
      assign m.data    = p1_r;
      assign occupancy = occ_r;

      // Two-entry FSM; s_ready/m_valid/occupancy are registered alongside the state.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_r   <= ST_EMPTY;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          occ_r     <= 2'd0;
        end else if (flush_s) begin
          state_r   <= ST_EMPTY;
          s_ready_r <= 1'b1;
          m_valid_r <= 1'b0;
          occ_r     <= 2'd0;
        end else begin
          case (state_r)
            ST_EMPTY: begin
              s_ready_r <= 1'b1;
              if (s_xfer_s) begin
                state_r   <= ST_ONE;
                p1_r      <= s.data;
                m_valid_r <= 1'b1;
                occ_r     <= 2'd1;
              end else begin
                state_r   <= ST_EMPTY;
                m_valid_r <= 1'b0;
                occ_r     <= 2'd0;
              end
            end
            ST_ONE: begin
              if (s_xfer_s && m.ready) begin
                state_r   <= ST_ONE;
                p1_r      <= s.data;
                s_ready_r <= 1'b1;
                m_valid_r <= 1'b1;
                occ_r     <= 2'd1;
              end else if (m.ready) begin
                state_r   <= ST_EMPTY;
                s_ready_r <= 1'b1;
                m_valid_r <= 1'b0;
                occ_r     <= 2'd0;
              end else if (s_xfer_s) begin
                // Downstream stalled: park the new word and close the upstream port.
                state_r   <= ST_TWO;
                p2_r      <= s.data;
                s_ready_r <= 1'b0;
                m_valid_r <= 1'b1;
                occ_r     <= 2'd2;
              end else begin
                state_r   <= ST_ONE;
                s_ready_r <= 1'b1;
                m_valid_r <= 1'b1;
                occ_r     <= 2'd1;
              end
            end
            ST_TWO: begin
              m_valid_r <= 1'b1;
              if (m.ready) begin
                state_r   <= ST_ONE;
                p1_r      <= p2_r;
                s_ready_r <= 1'b1;
                occ_r     <= 2'd1;
              end else begin
                state_r   <= ST_TWO;
                s_ready_r <= 1'b0;
                occ_r     <= 2'd2;
              end
            end
            default: begin
              state_r   <= ST_EMPTY;
              s_ready_r <= 1'b0;
              m_valid_r <= 1'b0;
              occ_r     <= 2'd0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule
